fp_compare_pipe: RTL and testbench
==================================

// Module: fp_compare_pipe
// PURPOSE
//   Pipelined IEEE-754 comparator for the FPU datapath, generalised in exponent/mantissa width.
//   Supports three ops: CMP (3-bit relation code), MIN and MAX (selected operand).
//   Handles NaN, infinity and signed zero.
//   Uses valid/ready handshakes on both sides and sits between the FP register-read stage and FP writeback.
// PARAMETERS
//   EXP_W   8    exponent width (8 = single, 11 = double)
//   MAN_W   23   stored mantissa width; operand width W = 1+EXP_W+MAN_W
//   TAG_W   5    width of the opaque tag carried alongside each operation (dest reg)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operation presented
//   in_ready   out  1      block can accept this cycle
//   in_op      in   2      0=CMP 1=MIN 2=MAX 3=reserved (treated as CMP)
//   in_a       in   W      operand A
//   in_b       in   W      operand B
//   in_tag     in   TAG_W  passthrough tag
//   out_valid  out  1      result presented
//   out_ready  in   1      consumer accepts this cycle
//   out_rel    out  3      100 A>B, 010 A==B, 001 A<B, 000 unordered
//   out_val    out  W      MIN/MAX result; 0 for CMP
//   out_tag    out  TAG_W  tag of this result
//   out_inv    out  1      invalid flag: either operand is a signalling NaN
// BEHAVIOUR
//   - Reset: all stage valid bits clear; out_valid=0 and out_rel=000; out_val, out_tag, out_inv = 0.
//     Reset takes effect immediately; in-flight ops are discarded, never emitted.
//   - Two register stages, S1 and S2. Latency is exactly 2 cycles from the accepting edge to
//     out_valid when out_ready is held high. Throughput is 1 op/cycle.
//   - Stall rule: a stage loads when it is empty or its contents advance the same edge.
//       S2 advances on out_valid && out_ready.
//       in_ready = !S1.valid || !S2.valid || out_ready (combinational).
//     No op is dropped or duplicated under backpressure. Output fields are stable while
//     out_valid && !out_ready.
//   - S1 (classify): per operand compute isnan, issnan, iszero, isinf, sign.
//       NaN  = exp all-ones and man != 0.
//       sNaN = NaN with man MSB = 0.
//       zero = exp == 0 and man == 0.
//     Also compute an unsigned magnitude compare of {exp,man} (mag_gt, mag_eq) and register it.
//   - S2 (resolve):
//       any NaN           -> rel=000.
//       both zero         -> rel=010 (+0 == -0).
//       signs differ      -> positive operand is greater.
//       both positive     -> rel from magnitude compare.
//       both negative     -> magnitude relation inverted; equal magnitudes give 010.
//     Denormals compare by bit pattern and need no special case.
//   - MIN/MAX:
//       one NaN    -> return the other operand.
//       both NaN   -> return canonical qNaN {0, all-ones exp, 1, zeros}.
//       zeros of opposite sign -> MIN returns -0, MAX returns +0.
//       equal non-zero values  -> return A.
//   - out_inv: asserted on any sNaN input, regardless of op.
//   - out_rel is still produced for MIN/MAX ops.
//   - A reserved op behaves as CMP.
//   - Simultaneous input accept and output pop on the same edge with both stages full is legal
//     and keeps full throughput.
// STRUCTURE
//   - Package fp_cmp_pkg holds:
//       REL_GT=3'b100, REL_EQ=3'b010, REL_LT=3'b001, REL_UN=3'b000
//       OP_CMP/OP_MIN/OP_MAX localparams
//       function canon_qnan(EXP_W, MAN_W)
//   - Sub-module fp_classify #(EXP_W,MAN_W): combinational class bits for one operand,
//     instantiated twice in S1.
//   - Pipeline regs and handshake logic stay in this module.
// TESTING
//   1. CMP 0x3F800000 (1.0) vs 0x40000000 (2.0) -> rel=001 two cycles after accept;
//      swapped operands -> 100.
//   2. CMP 0x00000000 vs 0x80000000 -> rel=010, inv=0.
//      CMP 0xC0000000 vs 0xBF800000 -> rel=001.
//   3. CMP 0x7FC00000 vs 0x3F800000 -> rel=000, inv=0.
//      CMP 0x7F800001 vs 0x3F800000 -> rel=000, inv=1.
//      MAX 0x7FC00000 vs 0x3F800000 -> val=0x3F800000.
//   4. MIN +0/-0 -> val=0x80000000; MAX +0/-0 -> val=0x00000000;
//      MIN of two qNaNs -> val=0x7FC00000.
//   5. Five back-to-back ops with tags 1..5; out_ready low for cycles 3-5.
//      -> in_ready=0 while both stages full; outputs emerge in tag order 1..5,
//         values held stable while stalled, none lost or repeated.
//   6. Assert rst with two ops in flight -> out_valid=0 immediately.
//      After release, one new op appears 2 cycles after accept with the correct result.
//      Repeat scenarios 1-3 with EXP_W=11, MAN_W=52 (e.g. 1.0 = 0x3FF0000000000000).

Source files
------------

// File: rtl/fp_cmp_pkg.sv
// Shared constants, operand class record and canonical quiet-NaN builder
// for the pipelined floating-point comparator.
package fp_cmp_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_EQ = 3'b010;
  localparam logic [2:0] REL_LT = 3'b001;
  localparam logic [2:0] REL_UN = 3'b000;

  typedef enum logic [1:0] {
    OP_CMP = 2'd0,
    OP_MIN = 2'd1,
    OP_MAX = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef struct packed {
    logic sign;
    logic isnan;
    logic issnan;
    logic iszero;
    logic isinf;
  } fp_class_t;

  // Positive quiet NaN: exponent all ones, mantissa MSB set, rest zero.
  // Built at MAX_W bits; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if ((i + 1 >= man_w) && (i < man_w + exp_w)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_compare_pipe_if.sv
// Request/response bundle for the FP comparator: valid/ready on the
// operand side and on the result side.
interface fp_compare_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_rel;
  logic [W-1:0]     out_val;
  logic [TAG_W-1:0] out_tag;
  logic             out_inv;

  // Environment side: issues operations and consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_rel, out_val, out_tag, out_inv
  );

  // Comparator side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_rel, out_val, out_tag, out_inv
  );

endinterface

// File: rtl/fp_compare_pipe_classify.sv
// Combinational IEEE-754 class bits for one operand.
module fp_classify
  import fp_cmp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output fp_class_t            cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             man_zero;

  assign exp_f    = x_i[MAN_W +: EXP_W];
  assign man_f    = x_i[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign man_zero = (man_f == '0);

  assign cls_o.sign   = x_i[EXP_W+MAN_W];
  assign cls_o.isnan  = exp_ones && !man_zero;
  assign cls_o.issnan = exp_ones && !man_zero && !man_f[MAN_W-1];
  assign cls_o.iszero = (exp_f == '0) && man_zero;
  assign cls_o.isinf  = exp_ones && man_zero;

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined IEEE-754 comparator with MIN/MAX selection.
// S1 classifies both operands and compares magnitudes; S2 resolves the
// relation and selected value and drives the result handshake.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 5
) (
  input logic              clk,
  input logic              rst,
  fp_compare_pipe_if.slave bus
);

  localparam int unsigned      W         = 1 + EXP_W + MAN_W;
  localparam logic [MAX_W-1:0] QNAN_FULL = canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  typedef struct packed {
    op_e              op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] tag;
    fp_class_t        ca;
    fp_class_t        cb;
    logic             mag_gt;
    logic             mag_eq;
  } s1_t;

  typedef struct packed {
    logic [2:0]       rel;
    logic [W-1:0]     val;
    logic [TAG_W-1:0] tag;
    logic             inv;
  } s2_t;

  fp_class_t cls_a;
  fp_class_t cls_b;
  logic      s1_valid_q, s1_valid_d;
  logic      s2_valid_q, s2_valid_d;
  s1_t       s1_q, s1_d;
  s2_t       s2_q, s2_d;
  s2_t       res;
  logic      s1_load;
  logic      s2_load;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x_i(bus.in_a), .cls_o(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x_i(bus.in_b), .cls_o(cls_b));

  // Handshake and S1 capture: a stage loads when empty or when its occupant leaves this edge.
  always_comb begin
    s2_load    = !s2_valid_q || bus.out_ready;
    s1_load    = !s1_valid_q || s2_load;
    s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s1_d       = s1_q;
    if (s1_load && bus.in_valid) begin
      s1_d.op     = op_e'(bus.in_op);
      s1_d.a      = bus.in_a;
      s1_d.b      = bus.in_b;
      s1_d.tag    = bus.in_tag;
      s1_d.ca     = cls_a;
      s1_d.cb     = cls_b;
      s1_d.mag_gt = bus.in_a[W-2:0] > bus.in_b[W-2:0];
      s1_d.mag_eq = bus.in_a[W-2:0] == bus.in_b[W-2:0];
    end
  end

  // S2 resolve: relation from class bits and magnitude order, then MIN/MAX selection.
  always_comb begin
    res     = '0;
    res.tag = s1_q.tag;
    res.inv = s1_q.ca.issnan || s1_q.cb.issnan;
    if (s1_q.ca.isnan || s1_q.cb.isnan)             res.rel = REL_UN;
    else if (s1_q.ca.iszero && s1_q.cb.iszero)      res.rel = REL_EQ;
    else if (s1_q.ca.sign != s1_q.cb.sign)          res.rel = s1_q.ca.sign ? REL_LT : REL_GT;
    else if (s1_q.ca.isinf && s1_q.cb.isinf)        res.rel = REL_EQ;
    else if (s1_q.mag_eq)                           res.rel = REL_EQ;
    else if (s1_q.mag_gt ^ s1_q.ca.sign)            res.rel = REL_GT;
    else                                            res.rel = REL_LT;

    case (s1_q.op)
      OP_MIN, OP_MAX: begin
        if (s1_q.ca.isnan && s1_q.cb.isnan)         res.val = QNAN;
        else if (s1_q.ca.isnan)                     res.val = s1_q.b;
        else if (s1_q.cb.isnan)                     res.val = s1_q.a;
        // Opposite-signed zeros: MIN prefers the negative one, MAX the positive one.
        else if (s1_q.ca.iszero && s1_q.cb.iszero)
          res.val = ((s1_q.op == OP_MIN) == s1_q.ca.sign) ? s1_q.a : s1_q.b;
        else if (s1_q.op == OP_MIN)                 res.val = (res.rel == REL_GT) ? s1_q.b : s1_q.a;
        else                                        res.val = (res.rel == REL_LT) ? s1_q.b : s1_q.a;
      end
      default: res.val = '0;
    endcase

    s2_d = (s2_load && s1_valid_q) ? res : s2_q;
  end

  // Pipeline state; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_rel   = s2_q.rel;
  assign bus.out_val   = s2_q.val;
  assign bus.out_tag   = s2_q.tag;
  assign bus.out_inv   = s2_q.inv;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench: a single-precision and a double-precision comparator
// share clock and reset; stimulus pushes hand-computed expectations and a
// forked monitor checks each presented result against the queue head.
module tb_fp_compare_pipe;

  localparam logic [1:0] CMP = 2'd0;
  localparam logic [1:0] MIN = 2'd1;
  localparam logic [1:0] MAX = 2'd2;
  localparam logic [1:0] RSV = 2'd3;

  typedef struct {
    logic [2:0]  rel;
    logic [63:0] val;
    logic [4:0]  tag;
    logic        inv;
    int          acc;
    bit          lat;
    bit          seen;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  int   inflight [2];
  exp_t qs[$];
  exp_t qd[$];
  logic [4:0] tg;

  fp_compare_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) sp ();
  fp_compare_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) dp ();

  fp_compare_pipe #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) u_sp (.clk(clk), .rst(rst), .bus(sp));
  fp_compare_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) u_dp (.clk(clk), .rst(rst), .bus(dp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? sp.in_ready : dp.in_ready;
  endfunction

  task automatic drive(input int d, input logic v, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    if (d == 0) begin
      sp.in_valid = v; sp.in_op = op; sp.in_a = a[31:0]; sp.in_b = b[31:0]; sp.in_tag = tag;
    end else begin
      dp.in_valid = v; dp.in_op = op; dp.in_a = a; dp.in_b = b; dp.in_tag = tag;
    end
  endtask

  // Present one op, wait (bounded) for acceptance, record the expectation.
  task automatic send(input int d, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input logic [2:0] rel, input logic [63:0] val,
                      input logic inv, input bit lat);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    drive(d, 1'b1, op, a, b, tag);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rdy(d)) begin
        ok = 1'b1;
        e.rel = rel; e.val = val; e.tag = tag; e.inv = inv;
        e.acc = cyc; e.lat = lat; e.seen = 1'b0;
        if (d == 0) qs.push_back(e); else qd.push_back(e);
      end
      @(posedge clk); #1;
    end
    drive(d, 1'b0, op, a, b, tag);
    if (!ok) fail("accept_timeout");
  endtask

  task automatic sendv(input int d, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] rel, input logic [63:0] val, input logic inv);
    tg = tg + 5'd1;
    send(d, op, a, b, tg, rel, val, inv, 1'b1);
  endtask

  task automatic mon_step(input int d, input logic ivld, input logic irdy, input logic ovld,
                          input logic ordy, input logic [2:0] rel, input logic [63:0] val,
                          input logic [4:0] tag, input logic inv);
    exp_t e;
    int   sz;
    // Both stages full exactly when two ops are in flight.
    chk(d == 0 ? "sp_in_ready" : "dp_in_ready", {63'd0, irdy}, {63'd0, (inflight[d] < 2) || ordy});
    if (ovld) begin
      sz = (d == 0) ? qs.size() : qd.size();
      if (sz == 0) fail(d == 0 ? "sp_unexpected_output" : "dp_unexpected_output");
      else begin
        e = (d == 0) ? qs[0] : qd[0];
        chk(d == 0 ? "sp_rel" : "dp_rel", {61'd0, rel}, {61'd0, e.rel});
        chk(d == 0 ? "sp_val" : "dp_val", val, e.val);
        chk(d == 0 ? "sp_tag" : "dp_tag", {59'd0, tag}, {59'd0, e.tag});
        chk(d == 0 ? "sp_inv" : "dp_inv", {63'd0, inv}, {63'd0, e.inv});
        if (e.lat && !e.seen) chk("latency", 64'(cyc - e.acc), 64'd2);
        if (d == 0) qs[0].seen = 1'b1; else qd[0].seen = 1'b1;
        if (ordy) begin
          if (d == 0) void'(qs.pop_front()); else void'(qd.pop_front());
        end
      end
    end
    inflight[d] = inflight[d] + ((ivld && irdy) ? 1 : 0) - ((ovld && ordy) ? 1 : 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight[0] = 0;
        inflight[1] = 0;
      end else begin
        mon_step(0, sp.in_valid, sp.in_ready, sp.out_valid, sp.out_ready, sp.out_rel,
                 {32'd0, sp.out_val}, sp.out_tag, sp.out_inv);
        mon_step(1, dp.in_valid, dp.in_ready, dp.out_valid, dp.out_ready, dp.out_rel,
                 dp.out_val, dp.out_tag, dp.out_inv);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (qs.size() != 0 || qd.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain_sp", 64'(qs.size()), 64'd0);
    chk("drain_dp", 64'(qd.size()), 64'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; tg = 5'd0;
    inflight[0] = 0; inflight[1] = 0;
    rst = 1'b1;
    drive(0, 1'b0, CMP, 64'd0, 64'd0, 5'd0);
    drive(1, 1'b0, CMP, 64'd0, 64'd0, 5'd0);
    sp.out_ready = 1'b1;
    dp.out_ready = 1'b1;
    fork monitor(); join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sp_out_valid", {63'd0, sp.out_valid}, 64'd0);
    chk("rst_sp_out_rel",   {61'd0, sp.out_rel},   64'd0);
    chk("rst_sp_out_val",   {32'd0, sp.out_val},   64'd0);
    chk("rst_sp_out_tag",   {59'd0, sp.out_tag},   64'd0);
    chk("rst_sp_out_inv",   {63'd0, sp.out_inv},   64'd0);
    chk("rst_sp_in_ready",  {63'd0, sp.in_ready},  64'd1);
    chk("rst_dp_out_valid", {63'd0, dp.out_valid}, 64'd0);
    chk("rst_dp_out_val",   dp.out_val,            64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single precision: ordering, signed zero, NaN handling, MIN/MAX, reserved op.
    sendv(0, CMP, 64'h3F800000, 64'h40000000, 3'b001, 64'h0,        1'b0);
    sendv(0, CMP, 64'h40000000, 64'h3F800000, 3'b100, 64'h0,        1'b0);
    sendv(0, CMP, 64'h00000000, 64'h80000000, 3'b010, 64'h0,        1'b0);
    sendv(0, CMP, 64'hC0000000, 64'hBF800000, 3'b001, 64'h0,        1'b0);
    sendv(0, CMP, 64'h7FC00000, 64'h3F800000, 3'b000, 64'h0,        1'b0);
    sendv(0, CMP, 64'h7F800001, 64'h3F800000, 3'b000, 64'h0,        1'b1);
    sendv(0, MAX, 64'h7FC00000, 64'h3F800000, 3'b000, 64'h3F800000, 1'b0);
    sendv(0, MIN, 64'h00000000, 64'h80000000, 3'b010, 64'h80000000, 1'b0);
    sendv(0, MAX, 64'h00000000, 64'h80000000, 3'b010, 64'h00000000, 1'b0);
    sendv(0, MIN, 64'h80000000, 64'h00000000, 3'b010, 64'h80000000, 1'b0);
    sendv(0, MIN, 64'h7FC00000, 64'h7FC00001, 3'b000, 64'h7FC00000, 1'b0);
    sendv(0, MIN, 64'h3F800000, 64'h40000000, 3'b001, 64'h3F800000, 1'b0);
    sendv(0, MAX, 64'h3F800000, 64'h40000000, 3'b001, 64'h40000000, 1'b0);
    sendv(0, MAX, 64'hC0000000, 64'hBF800000, 3'b001, 64'hBF800000, 1'b0);
    sendv(0, MIN, 64'hC0000000, 64'hBF800000, 3'b001, 64'hC0000000, 1'b0);
    sendv(0, RSV, 64'h3F800000, 64'h40000000, 3'b001, 64'h0,        1'b0);
    sendv(0, CMP, 64'h7F800000, 64'h7F800000, 3'b010, 64'h0,        1'b0);
    sendv(0, CMP, 64'hFF800000, 64'h7F7FFFFF, 3'b001, 64'h0,        1'b0);
    sendv(0, CMP, 64'h00000001, 64'h00000002, 3'b001, 64'h0,        1'b0);
    sendv(0, CMP, 64'h3F800000, 64'hBF800000, 3'b100, 64'h0,        1'b0);
    sendv(0, MIN, 64'h7F800001, 64'h3F800000, 3'b000, 64'h3F800000, 1'b1);
    sendv(0, CMP, 64'h7FC00000, 64'h7F800001, 3'b000, 64'h0,        1'b1);
    drain();

    // Backpressure: five back-to-back MAX ops, consumer stalls for three cycles.
    fork
      begin
        repeat (3) @(posedge clk);
        #1 sp.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 sp.out_ready = 1'b1;
      end
    join_none
    send(0, MAX, 64'h1, 64'h3, 5'd1, 3'b001, 64'h3, 1'b0, 1'b0);
    send(0, MAX, 64'h2, 64'h3, 5'd2, 3'b001, 64'h3, 1'b0, 1'b0);
    send(0, MAX, 64'h3, 64'h3, 5'd3, 3'b010, 64'h3, 1'b0, 1'b0);
    send(0, MAX, 64'h4, 64'h3, 5'd4, 3'b100, 64'h4, 1'b0, 1'b0);
    send(0, MAX, 64'h5, 64'h3, 5'd5, 3'b100, 64'h5, 1'b0, 1'b0);
    drain();

    // Reset with two ops in flight: both are discarded at once.
    send(0, CMP, 64'h3F800000, 64'h40000000, 5'd6, 3'b001, 64'h0, 1'b0, 1'b1);
    send(0, CMP, 64'h40000000, 64'h3F800000, 5'd7, 3'b100, 64'h0, 1'b0, 1'b1);
    qs.delete();
    rst = 1'b1;
    #1;
    chk("rst_flight_out_valid", {63'd0, sp.out_valid}, 64'd0);
    chk("rst_flight_out_rel",   {61'd0, sp.out_rel},   64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    sendv(0, MIN, 64'h40000000, 64'h3F800000, 3'b100, 64'h3F800000, 1'b0);
    drain();

    // Double precision repeats of the ordering / zero / NaN cases.
    sendv(1, CMP, 64'h3FF0000000000000, 64'h4000000000000000, 3'b001, 64'h0, 1'b0);
    sendv(1, CMP, 64'h4000000000000000, 64'h3FF0000000000000, 3'b100, 64'h0, 1'b0);
    sendv(1, CMP, 64'h0000000000000000, 64'h8000000000000000, 3'b010, 64'h0, 1'b0);
    sendv(1, CMP, 64'hC000000000000000, 64'hBFF0000000000000, 3'b001, 64'h0, 1'b0);
    sendv(1, CMP, 64'h7FF8000000000000, 64'h3FF0000000000000, 3'b000, 64'h0, 1'b0);
    sendv(1, CMP, 64'h7FF0000000000001, 64'h3FF0000000000000, 3'b000, 64'h0, 1'b1);
    sendv(1, MAX, 64'h7FF8000000000000, 64'h3FF0000000000000, 3'b000, 64'h3FF0000000000000, 1'b0);
    sendv(1, MIN, 64'h7FF8000000000000, 64'h7FF8000000000001, 3'b000, 64'h7FF8000000000000, 1'b0);
    sendv(1, MIN, 64'h0000000000000000, 64'h8000000000000000, 3'b010, 64'h8000000000000000, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
